// File: rtl/div_pkg.sv
// Shared definitions for the sequential radix-2 divider: defaults, FSM states
// and the iteration-counter width helper.
package div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam logic [WIDTH_DEF-1:0] DIV0_QUOT_DEF = 32'h0000_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  // The counter must be able to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and keep the trial subtraction when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_trial_bit;

  assign shifted = {rem, dvd_msb};
  assign trial   = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit   = ~trial[WIDTH+1];

  // The remainder is always below the divisor, so a kept difference fits in WIDTH bits.
  assign rem_next         = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with start/ready handshake.
// Signed two's-complement mode is built only when DIVIDE_SIGNED_EN is defined.
module seq_divider
  import div_pkg::*;
#(
  parameter int              WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0] DIV0_QUOT = WIDTH'(DIV0_QUOT_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic [WIDTH-1:0] a_orig;
  logic             div0;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

`ifdef DIVIDE_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q;
  logic neg_r;

  assign a_neg = sign & a[WIDTH-1];
  assign b_neg = sign & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign q_fix = neg_q ? -dvd_reg : dvd_reg;
  assign r_fix = neg_r ? -rem_reg : rem_reg;
`else
  logic unused_sign;

  assign unused_sign = sign;
  assign a_mag       = a;
  assign b_mag       = b;
  assign q_fix       = dvd_reg;
  assign r_fix       = rem_reg;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .dvd_msb  (dvd_reg[WIDTH-1]),
    .divisor  (dsr_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // The dividend register doubles as the quotient register: each RUN edge
  // shifts out a dividend bit and shifts in the new quotient bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_reg   <= '0;
      dvd_reg   <= '0;
      dsr_reg   <= '0;
      a_orig    <= '0;
      div0      <= 1'b0;
      ready     <= 1'b1;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVIDE_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_reg <= a_mag;
            dsr_reg <= b_mag;
            a_orig  <= a;
            div0    <= (b == '0);
            rem_reg <= '0;
            cnt     <= CW'(WIDTH);
            ready   <= 1'b0;
            state   <= RUN;
`ifdef DIVIDE_SIGNED_EN
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
`endif
          end
        end
        RUN: begin
          rem_reg <= rem_next;
          dvd_reg <= {dvd_reg[WIDTH-2:0], q_bit};
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (div0) begin
            quotient  <= DIV0_QUOT;
            remainder <= a_orig;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and random bench for seq_divider; expected signed results
// apply only when DIVIDE_SIGNED_EN is defined for the build.
module tb_seq_divider;

  localparam int N_VEC = 12;
  localparam int LAT   = 33;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sign;
  logic        ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[N_VEC];

  seq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .sign      (sign),
    .ready     (ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic waitReady(inout int lat);
    while (!ready && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                               output logic [31:0] q, output logic [31:0] r, output int lat);
    int guard;
    guard = 0;
    waitReady(guard);
    @(negedge clk);
    a     = ta;
    b     = tbv;
    sign  = ts;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    waitReady(lat);
    q = quotient;
    r = remainder;
  endtask

  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic ms,
                                output logic [31:0] q, output logic [31:0] r);
    logic sm;
    sm = ms;
`ifndef DIVIDE_SIGNED_EN
    sm = 1'b0;
`endif
    if (mb == 32'd0) begin
      q = 32'h0000_FFFF;
      r = ma;
    end else if (sm && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sm) begin
      q = $signed(ma) / $signed(mb);
      r = $signed(ma) % $signed(mb);
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
  endfunction

  initial begin
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] eq;
    logic [31:0] er;
    logic [31:0] ta;
    logic [31:0] tbv;
    logic        ts;
    int          lat;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sign  = 1'b0;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2};
    vecs[1]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0};
    vecs[2]  = '{32'h1234_5678, 32'd0,         1'b0, 32'h0000_FFFF, 32'h1234_5678};
    vecs[3]  = '{32'd0,         32'd5,         1'b0, 32'd0,         32'd0};
    vecs[4]  = '{32'd5,         32'd9,         1'b0, 32'd0,         32'd5};
    vecs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1,         32'd0};
    vecs[6]  = '{32'h8000_0000, 32'd3,         1'b0, 32'h2AAA_AAAA, 32'd2};
    vecs[10] = '{32'hFFFF_FFF9, 32'd0,         1'b1, 32'h0000_FFFF, 32'hFFFF_FFF9};
`ifdef DIVIDE_SIGNED_EN
    vecs[7]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[8]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1};
    vecs[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0};
    vecs[11] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE};
`else
    vecs[7]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'h7FFF_FFFC, 32'd1};
    vecs[8]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'd0,         32'd7};
    vecs[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0,         32'h8000_0000};
    vecs[11] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd0,         32'hFFFF_FF9C};
`endif

    #12;
    checkOutput("reset_ready", {31'd0, ready}, 32'd1);
    checkOutput("reset_q", quotient, 32'd0);
    checkOutput("reset_r", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N_VEC; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sign, q, r, lat);
      checkOutput($sformatf("vec%0d_q", i), q, vecs[i].q);
      checkOutput($sformatf("vec%0d_r", i), r, vecs[i].r);
      checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
    end

    // Operand changes and a start pulse during RUN must not disturb the result.
    @(negedge clk);
    a = 32'd100; b = 32'd7; sign = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'd1000; b = 32'd3; sign = 1'b1;
    lat = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("hold_q", quotient, vecs[N_VEC-1].q);
    checkOutput("hold_r", remainder, vecs[N_VEC-1].r);
    checkOutput("busy_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    waitReady(lat);
    checkOutput("ignore_q", quotient, 32'd14);
    checkOutput("ignore_r", remainder, 32'd2);
    checkOutput("ignore_lat", 32'(lat), 32'(LAT));

    // Holding start high re-accepts on the edge right after ready rises.
    @(negedge clk);
    a = 32'd100; b = 32'd7; sign = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    waitReady(lat);
    checkOutput("held1_q", quotient, 32'd14);
    checkOutput("held1_lat", 32'(lat), 32'(LAT));
    a = 32'd50;
    @(posedge clk);
    #1;
    checkOutput("held_reaccept", {31'd0, ready}, 32'd0);
    start = 1'b0;
    lat = 0;
    waitReady(lat);
    checkOutput("held2_q", quotient, 32'd7);
    checkOutput("held2_r", remainder, 32'd1);
    checkOutput("held2_lat", 32'(lat), 32'(LAT));

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", {31'd0, ready}, 32'd1);
    checkOutput("midrst_q", quotient, 32'd0);
    checkOutput("midrst_r", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'd100, 32'd7, 1'b0, q, r, lat);
    checkOutput("postrst_q", q, 32'd14);
    checkOutput("postrst_r", r, 32'd2);
    checkOutput("postrst_lat", 32'(lat), 32'(LAT));

    for (int i = 0; i < 1000; i++) begin
      ta  = $urandom;
      tbv = (i % 2 == 0) ? 32'($urandom) : (32'($urandom) & 32'd3);
      ts  = 1'($urandom_range(0, 1));
      model(ta, tbv, ts, eq, er);
      applyStimulus(ta, tbv, ts, q, r, lat);
      checkOutput($sformatf("rnd%0d_q a=%h b=%h s=%0d", i, ta, tbv, ts), q, eq);
      checkOutput($sformatf("rnd%0d_r a=%h b=%h s=%0d", i, ta, tbv, ts), r, er);
      checkOutput($sformatf("rnd%0d_lat", i), 32'(lat), 32'(LAT));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
